// File: rtl/ps2_host_tx.sv
//==============================================================================
// Module : ps2_host_tx
// Host-to-device PS/2 byte transmitter (open-drain via output enables) with
// ACK / NACK / timeout reporting. Macro PS2_TX_AUTO_RESEND_EN adds 2 retries.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int C_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(C_MAX + 1);
    localparam logic [CW-1:0] c_inh_start = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] c_inh_last  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] c_to_last   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    c_code_nack = 2'b01;
    localparam logic [1:0]    c_code_to   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [7:0]             shreg_q, shreg_d;
    logic                   parity_q, parity_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   data_oe_q, data_oe_d;
    logic                   nack_q, nack_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
`ifdef PS2_TX_AUTO_RESEND_EN
    logic [7:0]             byte_q, byte_d;
    logic [1:0]             retry_q, retry_d;
`endif

    logic       w_clk_s, w_data_s, w_fall, w_timeout;
    logic       w_fail;
    logic [1:0] w_fail_code;

    assign w_clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign w_data_s  = data_sync_q[SYNC_STAGES-1];
    assign w_fall    = clk_prev_q & ~w_clk_s;
    // Timeout only watches the phases where the device owns the clock.
    assign w_timeout = (state_q != S_IDLE) && (state_q != S_INHIBIT) && !w_fall && (cnt_q == c_to_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev_q  <= w_clk_s;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef PS2_TX_AUTO_RESEND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q  <= '0;
            retry_q <= '0;
        end else begin
            byte_q  <= byte_d;
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        nack_d      = nack_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        w_fail      = 1'b0;
        w_fail_code = c_code_nack;
`ifdef PS2_TX_AUTO_RESEND_EN
        byte_d      = byte_q;
        retry_d     = retry_q;
`endif
        // Our own inhibit pull produces a fall that must not disturb the inhibit count.
        if (w_fall && state_q != S_INHIBIT) cnt_d = '0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d   = tx_data;
                    parity_d  = ~^tx_data;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
`ifdef PS2_TX_AUTO_RESEND_EN
                    byte_d    = tx_data;
                    retry_d   = '0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == c_inh_start) data_oe_d = 1'b1;
                if (cnt_q == c_inh_last) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RTS;
                end
            end
            S_RTS: if (w_fall) state_d = S_DATA;
            S_DATA: begin
                if (w_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    data_oe_d = ~parity_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    nack_d  = w_data_s;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_clk_s && w_data_s) begin
                    if (nack_q) begin
                        w_fail = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!w_fail && w_timeout && state_d == state_q) begin
            w_fail      = 1'b1;
            w_fail_code = c_code_to;
        end

        if (w_fail) begin
`ifdef PS2_TX_AUTO_RESEND_EN
            if (retry_q != 2'd2) begin
                retry_d   = retry_q + 1'b1;
                shreg_d   = byte_q;
                bit_cnt_d = '0;
                cnt_d     = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_INHIBIT;
            end else
`endif
            begin
                state_d    = S_IDLE;
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                err_d      = 1'b1;
                err_code_d = w_fail_code;
            end
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign tx_busy     = (state_q != S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
//==============================================================================
// Module : tb_ps2_host_tx
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TO   = 600;
    localparam int SYNC = 2;
    localparam int HALF = 15;
`ifdef PS2_TX_AUTO_RESEND_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_busy, done, err;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  code;
        logic        chk_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_vec = 0, n_miss = 0, n_evt = 0;
    int          cyc = 0, evt_cyc = 0, last_fall_cyc = 0;
    int          run = 0, ovl = 0, last_inh = 0, last_ovl = 0, inh_phases = 0;
    logic        reaccept_pend = 1'b0;
    logic [10:0] rx_frame = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Inhibit phase length and the start-bit overlap inside it.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            run++;
            if (ps2_data_oe) ovl++;
        end else if (run != 0) begin
            last_inh = run;
            last_ovl = ovl;
            inh_phases++;
            run = 0;
            ovl = 0;
        end
    end

    // Monitor: pops one expectation per done/err pulse.
    always @(negedge clk) begin
        if (reaccept_pend) begin
            chk("reaccept_after_done", ps2_clk_oe, 1);
            reaccept_pend = 1'b0;
        end
        if (!rst && (done || err)) begin
            n_evt++;
            evt_cyc = cyc;
            chk("pending_expect", exp_q.size() == 0, 0);
            chk("done_err_exclusive", done & err, 0);
            if (exp_q.size() != 0) begin
                m_e = exp_q.pop_front();
                chk("evt_is_err", err, m_e.is_err);
                if (m_e.is_err) chk("err_code", err_code, m_e.code);
                if (m_e.chk_frame) chk("frame", rx_frame, m_e.frame);
            end
            if (done && tx_valid) begin
                chk("ready_at_done", tx_ready, 1);
                reaccept_pend = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic is_err, input logic [1:0] code, input logic chkf,
                            input logic [7:0] b, input logic par);
        exp_t e;
        e.is_err    = is_err;
        e.code      = code;
        e.chk_frame = chkf;
        e.frame     = {1'b1, par, b, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int g = 0;
        while (!tx_ready && g < 4 * TO) begin @(negedge clk); g++; end
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accepted_busy", tx_busy, 1);
    endtask

    // Device clocks the frame: samples on rising edges, answers ACK before fall 12.
    task automatic dev_frame(input logic ack_bit, input int nfalls, input logic end_low);
        int g = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && g < 2 * TO) begin
            @(negedge clk); g++;
        end
        chk("rts_seen", g < 2 * TO, 1);
        rx_frame = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk       = 1'b0;
            last_fall_cyc = cyc;
            if (end_low && i == nfalls) begin
                repeat (HALF / 2) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 11) rx_frame[i-1] = ps2_data_in;
            repeat (HALF / 2) @(negedge clk);
            if (i == 11) dev_data = ack_bit;
            if (i == 12) dev_data = 1'b1;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
    endtask

    task automatic wait_evt(input int e0);
        int g = 0;
        while (n_evt == e0 && g < 4 * TO) begin @(negedge clk); g++; end
        chk("evt_arrived", n_evt != e0, 1);
    endtask

    task automatic run_ok(input logic [7:0] b, input logic par);
        int e0 = n_evt;
        push_exp(1'b0, 2'b00, 1'b1, b, par);
        send(b);
        dev_frame(1'b0, 12, 1'b0);
        wait_evt(e0);
        chk("inhibit_len", last_inh, INH);
        chk("start_overlap", last_ovl, 1);
        chk("lines_idle", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        int e0, ph0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_pulses", {done, err}, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_ok(8'hED, 1'b1);
        run_ok(8'h00, 1'b1);

        // NACK
        e0  = n_evt;
        ph0 = inh_phases;
        push_exp(1'b1, 2'b01, 1'b0, 8'hFF, 1'b1);
        send(8'hFF);
        for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b1, 12, 1'b0);
        wait_evt(e0);
        chk("nack_inhibit_phases", inh_phases - ph0, ATTEMPTS);
        chk("nack_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);

        run_ok(8'h55, 1'b1);
        chk("err_code_hold", err_code, 2'b01);

        // Device stops after the 4th data bit
        e0 = n_evt;
        push_exp(1'b1, 2'b10, 1'b0, 8'hF0, 1'b1);
        send(8'hF0);
        for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b1, 5, 1'b0);
        wait_evt(e0);
        chk("timeout_latency", evt_cyc - last_fall_cyc, TO + SYNC + 1);
        chk("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);

        // Reset while bit 5 (a zero) is on the line
        send(8'h12);
        dev_frame(1'b0, 7, 1'b1);
        chk("pre_reset_data_oe", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("async_rst_ready", tx_ready, 1);
        chk("async_rst_err_code", err_code, 0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_ok(8'hF4, 1'b0);

        // tx_valid held through a frame, tx_data changed mid-frame
        e0 = n_evt;
        push_exp(1'b0, 2'b00, 1'b1, 8'h3C, 1'b1);
        push_exp(1'b0, 2'b00, 1'b1, 8'hC3, 1'b1);
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("hold_accept_busy", tx_busy, 1);
        tx_data = 8'hC3;
        dev_frame(1'b0, 12, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b0, 12, 1'b0);
        wait_evt(e0 + 1);
        chk("hold_inhibit_len", last_inh, INH);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire
